// File: rtl/sd_spi_init_ctrl.sv
// SPI-mode SD card initialiser: power-up clocks, CMD0/CMD8/CMD55+ACMD41/CMD58,
// reporting card version (v1/v2), capacity class (SC/HC) and a coded failure.
module sd_spi_init_ctrl #(
   parameter int POWERUP_CLKS = 512,
   parameter int GAP_CLKS     = 16,
   parameter int RSP_TIMEOUT  = 64,
   parameter int ACMD41_TRIES = 1024
) (
   input  logic       sdclk,
   input  logic       reset_n,
   input  logic       init_start,
   input  logic       dout,
   output logic       cs,
   output logic       din,
   output logic       init_ok,
   output logic       init_err,
   output logic [2:0] err_code,
   output logic       card_v2,
   output logic       card_hc,
   output logic       init_busy
);

   localparam int M1      = (POWERUP_CLKS > GAP_CLKS) ? POWERUP_CLKS : GAP_CLKS;
   localparam int M2      = (M1 > RSP_TIMEOUT) ? M1 : RSP_TIMEOUT;
   localparam int CNT_MAX = (M2 > 48) ? M2 : 48;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TRY_W   = $clog2(ACMD41_TRIES + 1);

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RSP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(47);
   localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(ACMD41_TRIES - 1);

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_CMD0  = 3'd1;
   localparam logic [2:0] E_CMD8  = 3'd2;
   localparam logic [2:0] E_CMD55 = 3'd3;
   localparam logic [2:0] E_A41   = 3'd4;
   localparam logic [2:0] E_TRIES = 3'd5;
   localparam logic [2:0] E_CMD58 = 3'd6;
   localparam logic [2:0] E_TOUT  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_PWRUP, S_SEND, S_RESP, S_GAP, S_DONE, S_ERR
   } state_t;

   typedef enum logic [2:0] {
      C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
   } cmd_t;

   function automatic logic [47:0] frame_of(input cmd_t c, input logic v2);
      logic [47:0] f;
      case (c)
         C_CMD0:   f = 48'h40_00000000_95;
         C_CMD8:   f = 48'h48_000001AA_87;
         C_CMD55:  f = 48'h77_00000000_65;
         C_ACMD41: f = v2 ? 48'h69_40000000_77 : 48'h69_00000000_E5;
         C_CMD58:  f = 48'h7A_00000000_FD;
         default:  f = 48'hFFFF_FFFF_FFFF;
      endcase
      return f;
   endfunction

   state_t           state_q, state_d;
   cmd_t             cmd_q, cmd_d;
   logic             fin_q, fin_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       rcnt_q, rcnt_d;
   logic [39:0]      rsp_q, rsp_d;
   logic [47:0]      sr_q, sr_d;
   logic [TRY_W-1:0] try_q, try_d;
   logic             cs_q, cs_d;
   logic             din_q, din_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic [2:0]       code_q, code_d;
   logic             v2_q, v2_d;
   logic             hc_q, hc_d;
   logic             busy_q, busy_d;

   logic [7:0] r1;
   logic [5:0] rsp_len;
   logic       rsp_done;

   // R1 sits in the low byte after an 8-bit response, in the top byte after 40 bits.
   assign r1       = (rcnt_q == 6'd8) ? rsp_q[7:0] : rsp_q[39:32];
   assign rsp_len  = (cmd_q == C_CMD8 || cmd_q == C_CMD58) ? 6'd40 : 6'd8;
   assign rsp_done = (rcnt_q == rsp_len) || (rcnt_q == 6'd8 && rsp_q[2]);

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      fin_d   = fin_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      rsp_d   = rsp_q;
      sr_d    = sr_q;
      try_d   = try_q;
      code_d  = code_q;
      v2_d    = v2_q;
      hc_d    = hc_q;

      case (state_q)
         S_IDLE: begin
            if (init_start) begin
               state_d = S_PWRUP;
               cnt_d   = '0;
               try_d   = '0;
               fin_d   = 1'b0;
               cmd_d   = C_CMD0;
            end
         end
         S_PWRUP: begin
            if (cnt_q == PWR_LAST) begin
               state_d = S_SEND;
               cmd_d   = C_CMD0;
               sr_d    = frame_of(C_CMD0, 1'b0);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SEND: begin
            sr_d = {sr_q[46:0], 1'b1};
            if (cnt_q == BIT_LAST) begin
               state_d = S_RESP;
               cnt_d   = '0;
               rcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_done) begin
               state_d = S_GAP;
               cnt_d   = '0;
               case (cmd_q)
                  C_CMD0: begin
                     if (r1 == 8'h01) cmd_d = C_CMD8;
                     else begin state_d = S_ERR; code_d = E_CMD0; end
                  end
                  C_CMD8: begin
                     if (r1 == 8'h05) begin
                        v2_d  = 1'b0;
                        cmd_d = C_CMD55;
                     end else if (r1 == 8'h01 && rsp_q[11:0] == 12'h1AA) begin
                        v2_d  = 1'b1;
                        cmd_d = C_CMD55;
                     end else begin
                        state_d = S_ERR;
                        code_d  = E_CMD8;
                     end
                  end
                  C_CMD55: begin
                     if (r1 == 8'h00 || r1 == 8'h01) cmd_d = C_ACMD41;
                     else begin state_d = S_ERR; code_d = E_CMD55; end
                  end
                  C_ACMD41: begin
                     if (r1 == 8'h01) begin
                        if (try_q == TRY_LAST) begin
                           state_d = S_ERR;
                           code_d  = E_TRIES;
                        end else begin
                           try_d = try_q + 1'b1;
                           cmd_d = C_CMD55;
                        end
                     end else if (r1 == 8'h00) begin
                        if (v2_q) cmd_d = C_CMD58;
                        else begin fin_d = 1'b1; hc_d = 1'b0; end
                     end else begin
                        state_d = S_ERR;
                        code_d  = E_A41;
                     end
                  end
                  C_CMD58: begin
                     if (r1 == 8'h00) begin hc_d = rsp_q[30]; fin_d = 1'b1; end
                     else begin state_d = S_ERR; code_d = E_CMD58; end
                  end
                  default: begin state_d = S_ERR; code_d = E_CMD0; end
               endcase
            end else if (rcnt_q != 6'd0 || !dout) begin
               rsp_d  = {rsp_q[38:0], dout};
               rcnt_d = rcnt_q + 6'd1;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_ERR;
               code_d  = E_TOUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (fin_q) state_d = S_DONE;
               else begin
                  state_d = S_SEND;
                  sr_d    = frame_of(cmd_q, v2_q);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase

      // Dropping init_start aborts from anywhere, including mid-frame.
      if (!init_start) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         rcnt_d  = '0;
         try_d   = '0;
         code_d  = E_NONE;
         v2_d    = 1'b0;
         hc_d    = 1'b0;
      end

      cs_d   = !(state_d == S_SEND || state_d == S_RESP);
      ok_d   = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
      busy_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);
      din_d  = (state_q == S_SEND) ? sr_q[47] : 1'b1;
   end

   always_ff @(posedge sdclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cmd_q   <= C_CMD0;
         fin_q   <= 1'b0;
         cnt_q   <= '0;
         rcnt_q  <= '0;
         rsp_q   <= '0;
         sr_q    <= '1;
         try_q   <= '0;
         cs_q    <= 1'b1;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= E_NONE;
         v2_q    <= 1'b0;
         hc_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         fin_q   <= fin_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
         rsp_q   <= rsp_d;
         sr_q    <= sr_d;
         try_q   <= try_d;
         cs_q    <= cs_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
         v2_q    <= v2_d;
         hc_q    <= hc_d;
         busy_q  <= busy_d;
      end
   end

   // MOSI changes on the falling edge so the card samples it mid-bit on the rising edge.
   always_ff @(negedge sdclk or negedge reset_n) begin
      if (!reset_n) din_q <= 1'b1;
      else          din_q <= din_d;
   end

   assign cs        = cs_q;
   assign din       = din_q | cs_q;
   assign init_ok   = ok_q;
   assign init_err  = err_q;
   assign err_code  = code_q;
   assign card_v2   = v2_q;
   assign card_hc   = hc_q;
   assign init_busy = busy_q;

endmodule

// File: tb/tb_sd_spi_init_ctrl.sv
// Bench for sd_spi_init_ctrl: a behavioural SPI SD card answers the controller;
// expected frames and final results are queued and checked by monitors.
module tb_sd_spi_init_ctrl;

   localparam int PWR = 512;
   localparam int TOUT = 64;

   localparam logic [47:0] F_CMD0  = 48'h40_00000000_95;
   localparam logic [47:0] F_CMD8  = 48'h48_000001AA_87;
   localparam logic [47:0] F_CMD55 = 48'h77_00000000_65;
   localparam logic [47:0] F_A41V2 = 48'h69_40000000_77;
   localparam logic [47:0] F_A41V1 = 48'h69_00000000_E5;
   localparam logic [47:0] F_CMD58 = 48'h7A_00000000_FD;

   typedef struct {
      logic       ok;
      logic       err;
      logic [2:0] code;
      logic       v2;
      logic       hc;
      int         lat;
   } res_t;

   logic       sdclk, reset_n, init_start, dout;
   logic       cs, din, init_ok, init_err, card_v2, card_hc, init_busy;
   logic [2:0] err_code;

   sd_spi_init_ctrl #(
      .POWERUP_CLKS (PWR),
      .GAP_CLKS     (16),
      .RSP_TIMEOUT  (TOUT),
      .ACMD41_TRIES (4)
   ) dut (
      .sdclk      (sdclk),
      .reset_n    (reset_n),
      .init_start (init_start),
      .dout       (dout),
      .cs         (cs),
      .din        (din),
      .init_ok    (init_ok),
      .init_err   (init_err),
      .err_code   (err_code),
      .card_v2    (card_v2),
      .card_hc    (card_hc),
      .init_busy  (init_busy)
   );

   int          nchk = 0, nfail = 0;
   int          cyc = 0, last_cmd_end = 0, frames_rx = 0, res_seen = 0;
   int          idle_viol = 0, both_viol = 0;
   logic [47:0] exp_frames[$];
   res_t        exp_res[$];

   // card behaviour knobs
   logic [7:0]  c_r1_cmd0;
   logic        c_silent0, c_v1, c_hc;
   logic [11:0] c_echo;
   int          c_busy, c_ncr, a41_cnt;

   initial begin
      sdclk = 1'b0;
      forever #5 sdclk = ~sdclk;
   end

   always @(posedge sdclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, {47'd0, act}, {47'd0, exp});
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      chk(nm, {16'd0, act}, {16'd0, exp});
   endtask

   function automatic res_t mk(input logic ok, input logic err, input logic [2:0] code,
                               input logic v2, input logic hc, input int lat);
      res_t r;
      r.ok = ok; r.err = err; r.code = code; r.v2 = v2; r.hc = hc; r.lat = lat;
      return r;
   endfunction

   task automatic cfg(input logic [7:0] r1c0, input logic silent0, input logic v1,
                      input logic [11:0] echo, input int busy, input logic hc, input int ncr);
      c_r1_cmd0 = r1c0; c_silent0 = silent0; c_v1 = v1; c_echo = echo;
      c_busy = busy; c_hc = hc; c_ncr = ncr; a41_cnt = 0;
   endtask

   task automatic tick;
      @(posedge sdclk);
      #2;
   endtask

   // Behavioural card: shifts in frames on rising edges, answers on falling edges.
   initial begin : card_model
      logic [47:0] fr, expf;
      logic [39:0] rsp;
      int          rlen;
      bit          ok_fr;
      dout = 1'b1;
      forever begin
         @(posedge sdclk); #1;
         if (!cs && !din) begin
            fr    = {47'd0, din};
            ok_fr = 1'b1;
            for (int i = 1; i < 48; i++) begin
               @(posedge sdclk); #1;
               if (cs) begin ok_fr = 1'b0; break; end
               fr = {fr[46:0], din};
            end
            if (ok_fr) begin
               last_cmd_end = cyc;
               frames_rx++;
               if (exp_frames.size() == 0) begin
                  nchk++; nfail++;
                  $display("FAIL cmd_frame: actual=%h required=none", fr);
               end else begin
                  expf = exp_frames.pop_front();
                  chk("cmd_frame", fr, expf);
               end
               rlen = 8;
               rsp  = '0;
               case (fr[45:40])
                  6'd0:  begin rsp = {c_r1_cmd0, 32'h0}; if (c_silent0) rlen = 0; end
                  6'd8:  begin
                     if (c_v1) rsp = {8'h05, 32'h0};
                     else begin rsp = {8'h01, 20'h00000, c_echo}; rlen = 40; end
                  end
                  6'd55: rsp = {8'h01, 32'h0};
                  6'd41: begin a41_cnt++; rsp = {(a41_cnt <= c_busy) ? 8'h01 : 8'h00, 32'h0}; end
                  6'd58: begin rsp = {8'h00, c_hc ? 32'hC0FF8000 : 32'h80FF8000}; rlen = 40; end
                  default: rlen = 0;
               endcase
               if (rlen > 0) begin
                  repeat (c_ncr) begin @(negedge sdclk); dout = 1'b1; end
                  for (int i = 0; i < rlen; i++) begin @(negedge sdclk); dout = rsp[39 - i]; end
                  @(negedge sdclk); dout = 1'b1;
               end
            end
         end
      end
   end

   // Result monitor: compares the final status against the queued expectation.
   initial begin : result_monitor
      logic prev_done;
      res_t r;
      prev_done = 1'b0;
      forever begin
         tick();
         if (reset_n && (init_ok || init_err) && !prev_done) begin
            res_seen++;
            if (exp_res.size() == 0) begin
               nchk++; nfail++;
               $display("FAIL result: actual ok=%b err=%b required=none", init_ok, init_err);
            end else begin
               r = exp_res.pop_front();
               chk1("res_ok", init_ok, r.ok);
               chk1("res_err", init_err, r.err);
               chki("res_code", int'(err_code), int'(r.code));
               chk1("res_v2", card_v2, r.v2);
               chk1("res_hc", card_hc, r.hc);
               chk1("res_busy", init_busy, 1'b0);
               chk1("res_cs", cs, 1'b1);
               if (r.lat >= 0) chki("rsp_timeout_lat", cyc - last_cmd_end, r.lat);
            end
         end
         prev_done = init_ok || init_err;
         if (cs && !din) idle_viol++;
         if (init_ok && init_err) both_viol++;
      end
   end

   task automatic wait_result(input int maxc);
      int s;
      s = res_seen;
      for (int i = 0; i < maxc; i++) begin
         if (res_seen != s) break;
         tick();
      end
      chk1("result_seen", res_seen != s, 1'b1);
   endtask

   task automatic run_case(input string nm, input res_t r);
      exp_res.push_back(r);
      init_start = 1'b1;
      wait_result(5000);
      chki({nm, "_frames_left"}, exp_frames.size(), 0);
      exp_frames.delete();
      exp_res.delete();
      init_start = 1'b0;
      tick(); tick();
      chk1("clr_ok", init_ok, 1'b0);
      chk1("clr_err", init_err, 1'b0);
      chki("clr_code", int'(err_code), 0);
      chk1("clr_v2", card_v2, 1'b0);
      chk1("clr_busy", init_busy, 1'b0);
   endtask

   task automatic wait_cs(input logic val, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (cs == val) break;
         tick();
      end
      chk1("cs_wait", cs, val);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int c, base;
      reset_n    = 1'b0;
      init_start = 1'b0;
      cfg(8'h01, 1'b0, 1'b0, 12'h1AA, 0, 1'b1, 1);
      tick(); tick(); tick();
      chk1("rst_cs", cs, 1'b1);
      chk1("rst_din", din, 1'b1);
      chk1("rst_ok", init_ok, 1'b0);
      chk1("rst_err", init_err, 1'b0);
      chki("rst_code", int'(err_code), 0);
      chk1("rst_v2", card_v2, 1'b0);
      chk1("rst_hc", card_hc, 1'b0);
      chk1("rst_busy", init_busy, 1'b0);
      reset_n = 1'b1;
      tick(); tick();

      // SDHC v2 card, busy for three ACMD41 rounds
      cfg(8'h01, 1'b0, 1'b0, 12'h1AA, 3, 1'b1, 4);
      exp_frames.push_back(F_CMD0);
      exp_frames.push_back(F_CMD8);
      repeat (4) begin exp_frames.push_back(F_CMD55); exp_frames.push_back(F_A41V2); end
      exp_frames.push_back(F_CMD58);
      run_case("sdhc_v2", mk(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, -1));

      // v1 card rejects CMD8; no CMD58 expected
      cfg(8'h01, 1'b0, 1'b1, 12'h000, 1, 1'b1, 1);
      exp_frames.push_back(F_CMD0);
      exp_frames.push_back(F_CMD8);
      repeat (2) begin exp_frames.push_back(F_CMD55); exp_frames.push_back(F_A41V1); end
      run_case("sd_v1", mk(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, -1));

      // silent after CMD0 -> timeout exactly RSP_TIMEOUT cycles after the last bit
      cfg(8'h01, 1'b1, 1'b0, 12'h1AA, 0, 1'b0, 1);
      exp_frames.push_back(F_CMD0);
      run_case("timeout", mk(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, TOUT));

      // ACMD41 never ready -> four attempts then retries exhausted
      cfg(8'h01, 1'b0, 1'b0, 12'h1AA, 1000, 1'b0, 2);
      exp_frames.push_back(F_CMD0);
      exp_frames.push_back(F_CMD8);
      repeat (4) begin exp_frames.push_back(F_CMD55); exp_frames.push_back(F_A41V2); end
      run_case("tries", mk(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, -1));

      // bad CMD8 echo
      cfg(8'h01, 1'b0, 1'b0, 12'h1A5, 0, 1'b0, 1);
      exp_frames.push_back(F_CMD0);
      exp_frames.push_back(F_CMD8);
      run_case("bad_echo", mk(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, -1));

      // CMD0 answered with R1=00
      cfg(8'h00, 1'b0, 1'b0, 12'h1AA, 0, 1'b0, 1);
      exp_frames.push_back(F_CMD0);
      run_case("cmd0_bad", mk(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, -1));

      // abort in the middle of CMD8, then a full fresh run
      cfg(8'h01, 1'b0, 1'b0, 12'h1AA, 0, 1'b1, 1);
      exp_frames.push_back(F_CMD0);
      base = frames_rx;
      init_start = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (frames_rx != base) break;
         tick();
      end
      chki("abort_cmd0_seen", frames_rx - base, 1);
      wait_cs(1'b1, 200);
      wait_cs(1'b0, 200);
      repeat (20) tick();
      init_start = 1'b0;
      tick();
      chk1("abort_cs", cs, 1'b1);
      chk1("abort_din", din, 1'b1);
      chk1("abort_busy", init_busy, 1'b0);
      chki("abort_frames_left", exp_frames.size(), 0);
      tick();
      exp_frames.push_back(F_CMD0);
      exp_frames.push_back(F_CMD8);
      exp_frames.push_back(F_CMD55);
      exp_frames.push_back(F_A41V2);
      exp_frames.push_back(F_CMD58);
      init_start = 1'b1;
      c = cyc;
      tick();
      chk1("rerun_busy", init_busy, 1'b1);
      wait_cs(1'b0, 2000);
      chki("pwrup_clks", cyc - c - 1, PWR);
      run_case("rerun", mk(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, -1));

      chki("idle_din_high", idle_viol, 0);
      chki("ok_err_exclusive", both_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
